// File: rtl/scan_ctrl.sv
// scan_ctrl: drives one load / capture / unload test on an external scan chain.
//
// Ports
//   CK      clock, rising edge
//   RN      asynchronous active-low reset
//   START   request a test (only looked at in IDLE)
//   PAT_IN  pattern to load, bit i lands in chain flop i
//   SO      scan-out from chain flop CHAIN_LEN-1
//   SI      scan-in to chain flop 0
//   SE      scan enable (1 = shift, 0 = functional capture)
//   BUSY    high whenever not IDLE
//   DONE    one-cycle pulse, RESP valid
//   RESP    captured response, bit i = value captured in chain flop i
//
// Optional feature (macro SCAN_CTRL_COMPARE_EN): adds EXP input and FAIL
// output; FAIL = (RESP != EXP) from FINISH until the next test starts.
//
// Every output is a flop loaded from the next-state decode, so the chain
// sees SE/SI stable for the whole cycle before the edge it acts on.
module scan_ctrl #(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic                 SO,
`ifdef SCAN_CTRL_COMPARE_EN
  input  logic [CHAIN_LEN-1:0] EXP,
  output logic                 FAIL,
`endif
  output logic                 SI,
  output logic                 SE,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP
);

  localparam int CW = $clog2(CHAIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FINISH} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [CHAIN_LEN-1:0] pat, pat_n;
  logic [CHAIN_LEN-1:0] resp_n;
  logic                 si_n, se_n, busy_n, done_n;
  // Low for the first edge after reset release so START cannot be taken there.
  logic                 armed;
`ifdef SCAN_CTRL_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_q, exp_n;
  logic                 fail_n;
`endif

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      cnt   <= '0;
      pat   <= '0;
      RESP  <= '0;
      SI    <= 1'b0;
      SE    <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      armed <= 1'b0;
`ifdef SCAN_CTRL_COMPARE_EN
      exp_q <= '0;
      FAIL  <= 1'b0;
`endif
    end else begin
      cnt   <= cnt_n;
      pat   <= pat_n;
      RESP  <= resp_n;
      SI    <= si_n;
      SE    <= se_n;
      BUSY  <= busy_n;
      DONE  <= done_n;
      armed <= 1'b1;
`ifdef SCAN_CTRL_COMPARE_EN
      exp_q <= exp_n;
      FAIL  <= fail_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pat_n   = pat;
    resp_n  = RESP;
    si_n    = 1'b0;
    se_n    = 1'b0;
    busy_n  = 1'b1;
    done_n  = 1'b0;
`ifdef SCAN_CTRL_COMPARE_EN
    exp_n   = exp_q;
    fail_n  = FAIL;
`endif
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (START && armed) begin
          state_n = SHIFT_IN;
          cnt_n   = '0;
          pat_n   = PAT_IN;
          si_n    = PAT_IN[CHAIN_LEN-1];  // MSB goes out first
          se_n    = 1'b1;
          busy_n  = 1'b1;
`ifdef SCAN_CTRL_COMPARE_EN
          exp_n   = EXP;
          fail_n  = 1'b0;
`endif
        end
      end
      SHIFT_IN: begin
        // pat is kept left-aligned so the next bit to present is always at CHAIN_LEN-2
        pat_n = pat << 1;
        if (cnt == LAST) begin
          state_n = CAPTURE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
          se_n  = 1'b1;
          si_n  = pat[CHAIN_LEN-2];
        end
      end
      CAPTURE: begin
        state_n = SHIFT_OUT;
        se_n    = 1'b1;
      end
      SHIFT_OUT: begin
        // first sample is flop CHAIN_LEN-1; after CHAIN_LEN shifts it sits in the MSB
        resp_n = {RESP[CHAIN_LEN-2:0], SO};
        if (cnt == LAST) begin
          state_n = FINISH;
          cnt_n   = '0;
          done_n  = 1'b1;
`ifdef SCAN_CTRL_COMPARE_EN
          fail_n  = (resp_n != exp_q);
`endif
        end else begin
          cnt_n = cnt + 1'b1;
          se_n  = 1'b1;
        end
      end
      FINISH: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_ctrl.sv
// tb_scan_ctrl: scan_ctrl driving an 8-flop chain whose functional D is the
// inverse of each flop's own Q, so a loaded pattern P comes back as ~P.
module tb_scan_ctrl;
  localparam int CL = 8;

  logic          CK, RN, START, SO, SI, SE, BUSY, DONE;
  logic [CL-1:0] PAT_IN, RESP;
  logic [CL-1:0] chain;
`ifdef SCAN_CTRL_COMPARE_EN
  logic [CL-1:0] EXP;
  logic          FAIL;
`endif

  int n_chk = 0;
  int n_fail = 0;

  scan_ctrl #(.CHAIN_LEN(CL)) dut (
    .CK(CK), .RN(RN), .START(START), .PAT_IN(PAT_IN), .SO(SO),
`ifdef SCAN_CTRL_COMPARE_EN
    .EXP(EXP), .FAIL(FAIL),
`endif
    .SI(SI), .SE(SE), .BUSY(BUSY), .DONE(DONE), .RESP(RESP)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // chain under test: flop 0 at SI, flop CL-1 at SO
  always @(posedge CK) chain <= SE ? {chain[CL-2:0], SI} : ~chain;
  assign SO = chain[CL-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full test from a START pulse; checks every cycle against the
  // waveform the controller should produce. Cycle n is the cycle after E(n).
  task automatic run_test(input logic [CL-1:0] p, input bit noise);
    logic [CL-1:0] r;
    bit exp_se, exp_si;
    r = ~p;
    @(negedge CK);
    START = 1'b1;
    PAT_IN = p;
    @(posedge CK);  // E0
    for (int n = 0; n <= 2*CL+1; n++) begin
      @(negedge CK);
      if (noise && n < 2*CL+1) begin
        START  = 1'($urandom);
        PAT_IN = CL'($urandom);
      end else begin
        START = 1'b0;
      end
      exp_se = (n < CL) || (n > CL && n <= 2*CL);
      exp_si = (n < CL) ? p[CL-1-n] : 1'b0;
      chk($sformatf("se[%0d]", n), SE, exp_se);
      chk($sformatf("si[%0d]", n), SI, exp_si);
      chk($sformatf("busy[%0d]", n), BUSY, 1);
      chk($sformatf("done[%0d]", n), DONE, n == 2*CL+1);
    end
    chk("resp", RESP, r);
`ifdef SCAN_CTRL_COMPARE_EN
    chk("fail", FAIL, r != EXP);
`endif
    @(negedge CK);
    chk("idle_busy", BUSY, 0);
    chk("idle_done", DONE, 0);
    chk("resp_hold", RESP, r);
`ifdef SCAN_CTRL_COMPARE_EN
    chk("fail_hold", FAIL, r != EXP);
`endif
  endtask

  initial begin
    int nd, d0, d1;
    bit seen;
    logic [CL-1:0] p;
    RN = 1'b0;
    START = 1'b0;
    PAT_IN = '0;
`ifdef SCAN_CTRL_COMPARE_EN
    EXP = '0;
`endif
    repeat (2) @(negedge CK);
    chk("rst_se", SE, 0);
    chk("rst_si", SI, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_resp", RESP, 0);
    RN = 1'b1;
    repeat (2) @(negedge CK);

`ifdef SCAN_CTRL_COMPARE_EN
    EXP = 8'h5A;
`endif
    run_test(8'hA5, 1'b0);
    run_test(8'h01, 1'b0);
`ifdef SCAN_CTRL_COMPARE_EN
    EXP = 8'h5B;
    run_test(8'hA5, 1'b0);
    EXP = 8'h0F;
`endif
    run_test(8'hF0, 1'b1);  // START/PAT_IN noise while busy

    // START held high: DONE after E17 and E36
    @(negedge CK);
    START = 1'b1;
    PAT_IN = 8'hA5;
    nd = 0; d0 = -1; d1 = -1;
    @(posedge CK);
    for (int n = 0; n < 40; n++) begin
      @(negedge CK);
      if (DONE) begin
        if (nd == 0) d0 = n;
        else if (nd == 1) d1 = n;
        nd++;
      end
    end
    START = 1'b0;
    chk("b2b_count", nd, 2);
    chk("b2b_done0", d0, 17);
    chk("b2b_done1", d1, 36);
    repeat (25) @(negedge CK);
    chk("b2b_idle", BUSY, 0);
    chk("b2b_resp", RESP, 8'h5A);

    // reset in shift cycle 5, then START held across reset release
    @(negedge CK);
    START = 1'b1;
    PAT_IN = 8'hFF;
    @(posedge CK);
    @(negedge CK);
    START = 1'b0;
    repeat (5) @(negedge CK);
    #1 RN = 1'b0;
    #1;
    chk("mid_rst_se", SE, 0);
    chk("mid_rst_si", SI, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_resp", RESP, 0);
    START = 1'b1;
    PAT_IN = 8'h3C;
    @(negedge CK);
    RN = 1'b1;
    @(posedge CK);
    @(negedge CK);
    chk("arm_first_edge", BUSY, 0);
    @(posedge CK);
    @(negedge CK);
    chk("arm_second_edge", BUSY, 1);
    START = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge CK);
      if (DONE) seen = 1'b1;
    end
    chk("post_rst_done", seen, 1);
    chk("post_rst_resp", RESP, 8'hC3);
    @(negedge CK);

    for (int i = 0; i < 10; i++) begin
      p = CL'($urandom);
`ifdef SCAN_CTRL_COMPARE_EN
      EXP = $urandom_range(0, 1) ? ~p : CL'($urandom);
`endif
      run_test(p, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 Parameter: CHAIN_LEN, default 16, number of DFF cells in the controlled scan chain; legal range 2..256.
REQ-002 Port: CK  input  1  clock; all state changes on the rising edge.
REQ-003 Port: RN  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: START  input  1  request one load/capture/unload test; sampled only in IDLE.
REQ-005 Port: PAT_IN  input  CHAIN_LEN  pattern to load; bit i targets chain flop i (flop 0 at SI end, flop CHAIN_LEN-1 at SO end).
REQ-006 Port: SO  input  1  scan-out, taken from the Q of chain flop CHAIN_LEN-1.
REQ-007 Port: SI  output  1  scan-in, drives the D path of chain flop 0.
REQ-008 Port: SE  output  1  scan enable; 1 selects shift path, 0 selects functional (capture) path.
REQ-009 Port: BUSY  output  1  high in every state except IDLE.
REQ-010 Port: DONE  output  1  one-cycle pulse; RESP valid while high.
REQ-011 Port: RESP  output  CHAIN_LEN  captured response; RESP[i] equals the value captured in chain flop i.

Function
REQ-012 FSM states: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FINISH; all outputs registered.
REQ-013 IDLE: SE=0, SI=0, BUSY=0, DONE=0; START=1 at edge E0 latches PAT_IN, clears the bit counter and enters SHIFT_IN.
REQ-014 SHIFT_IN: exactly CHAIN_LEN cycles (edges E1..E(CHAIN_LEN)); SE=1; SI=PAT[CHAIN_LEN-1-k] in shift cycle k (k=0 first), so the MSB is shifted first.
REQ-015 CAPTURE: exactly one cycle, edge E(CHAIN_LEN+1); SE=0, SI=0.
REQ-016 SHIFT_OUT: exactly CHAIN_LEN cycles (edges E(CHAIN_LEN+2)..E(2*CHAIN_LEN+1)); SE=1, SI=0; SO sampled at each edge, and the k-th sample is written into RESP[CHAIN_LEN-1-k].
REQ-017 FINISH: one cycle following edge E(2*CHAIN_LEN+1); DONE=1, BUSY=1, SE=0; next edge returns to IDLE.
REQ-018 Bit counter width is clog2(CHAIN_LEN); it counts 0..CHAIN_LEN-1, wraps to 0 on each state exit and never overflows.
REQ-019 START is ignored in all states other than IDLE; PAT_IN changes after E0 have no effect on the current test.
REQ-020 START held high continuously starts a new test on the first IDLE cycle after FINISH (back-to-back period 2*CHAIN_LEN+3 cycles).
REQ-021 RESP holds its value from FINISH until the next SHIFT_OUT overwrites it.

Reset
REQ-022 RN low asynchronously forces IDLE, SE=0, SI=0, BUSY=0, DONE=0, RESP=0, counter=0 and latched pattern=0, including mid-SHIFT_IN/CAPTURE/SHIFT_OUT.
REQ-023 After RN deasserts, the first START is sampled no earlier than the second rising CK edge.

Configuration
REQ-024 Macro SCAN_CTRL_COMPARE_EN: when defined, add ports EXP (input, CHAIN_LEN) and FAIL (output, 1); EXP latched at E0; FAIL registered in FINISH as (RESP != EXP) and held until the next E0 or reset (reset value 0).
REQ-025 Without SCAN_CTRL_COMPARE_EN the EXP and FAIL ports and their logic are absent; all other behaviour is identical.

Verification
REQ-026 Bench: CHAIN_LEN=8 chain of DFF cells, functional D of flop i = INV of its own Q, mux on SE; PAT_IN=8'hA5, START pulse -> SE high 8 cycles, low 1, high 8; DONE after edge E17; RESP=8'h5A.
REQ-027 PAT_IN=8'h01 -> SI sequence 0,0,0,0,0,0,0,1 during SHIFT_IN; RESP=8'hFE.
REQ-028 START pulsed again during SHIFT_OUT -> ignored, exactly one DONE pulse; START held high for 40 cycles -> DONE after E17 and E36.
REQ-029 RN pulsed low at cycle 5 of SHIFT_IN -> immediately SE=0, BUSY=0, RESP=0; next START with 8'h3C -> RESP=8'hC3.
REQ-030 With SCAN_CTRL_COMPARE_EN: PAT 8'hA5, EXP 8'h5A -> FAIL=0; EXP 8'h5B -> FAIL=1 from FINISH until the next START.
